// File: rtl/uart_tty_core_if.sv
// Host-side handshake bundle for uart_tty_core: TX byte stream, RX FIFO head and sticky error flags.
interface uart_tty_core_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 5
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [CNT_W-1:0]     rx_count;
    logic                 rx_overrun;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 err_clear;

    modport master (
        output tx_data, tx_valid, rx_ready, err_clear,
        input  tx_ready, rx_data, rx_valid, rx_count, rx_overrun, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, err_clear,
        output tx_ready, rx_data, rx_valid, rx_count, rx_overrun, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_tty_core.sv
// UART transceiver: TX serialiser, oversampled RX deserialiser feeding a first-word fall-through
// RX FIFO, sticky error flags and an optional echo (loopback) mode.
module uart_tty_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int LOOPBACK   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              srx,
    output logic              stx,
    uart_tty_core_if.slave    bus
);
    localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BIT_CYC + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int NW       = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] BIT_FULL  = CW'(BIT_CYC);
    localparam logic [CW-1:0] BIT_HALF  = CW'(BIT_CYC / 2);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);
    localparam bit HAS_PAR = (PARITY != 0);
    localparam bit ODD_PAR = (PARITY == 1);
    localparam bit LB      = (LOOPBACK != 0);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 stx_q, stx_d;

    logic                 srx_meta_q, srx_meta_d;
    logic                 srx_sync_q, srx_sync_d;
    logic                 srx_prev_q, srx_prev_d;
    state_t               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_push_q, rx_push_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;

    logic                 fifo_empty, fifo_full, push, pop, tx_start, tx_bit_end, rx_sample;
    logic                 frame_set, parity_set, overrun_set;
    logic [DATA_BITS-1:0] fifo_head, tx_src;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FIFO_FULL);
    assign fifo_head   = mem[rd_ptr_q];
    // In echo mode the transmitter is the FIFO's only consumer and the host ports are ignored.
    assign tx_start    = (tx_state_q == ST_IDLE) && (LB ? !fifo_empty : bus.tx_valid);
    assign tx_src      = LB ? fifo_head : bus.tx_data;
    assign pop         = !fifo_empty && (LB ? tx_start : bus.rx_ready);
    assign push        = rx_push_q && (!fifo_full || pop);
    assign overrun_set = rx_push_q && fifo_full && !pop;
    assign tx_bit_end  = (tx_cnt_q == BIT_LAST);
    assign rx_sample   = (rx_state_q == ST_START) ? (rx_cnt_q == BIT_HALF) : (rx_cnt_q == BIT_FULL);

    assign stx               = stx_q;
    assign bus.tx_ready      = !LB && (tx_state_q == ST_IDLE);
    assign bus.rx_valid      = !LB && !fifo_empty;
    assign bus.rx_data       = bus.rx_valid ? fifo_head : '0;
    assign bus.rx_count      = count_q;
    assign bus.rx_overrun    = overrun_q;
    assign bus.rx_frame_err  = frame_err_q;
    assign bus.rx_parity_err = parity_err_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        stx_d      = stx_q;
        if (tx_state_q != ST_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            ST_IDLE: begin
                stx_d = 1'b1;
                if (tx_start) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_src;
                    tx_par_d   = (^tx_src) ^ ODD_PAR;
                    stx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                    stx_d      = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == DATA_LAST) begin
                        if (HAS_PAR) begin
                            tx_state_d = ST_PARITY;
                            stx_d      = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            tx_bit_d   = '0;
                            stx_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        stx_d      = tx_shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = ST_STOP;
                    tx_bit_d   = '0;
                    stx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // The bit counter restarts at 1 on every transition so it always holds cycles since the last sample.
    always_comb begin
        srx_meta_d = srx;
        srx_sync_d = srx_meta_q;
        srx_prev_d = srx_sync_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_perr_d  = rx_perr_q;
        rx_push_d  = 1'b0;
        rx_byte_d  = rx_byte_q;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        if (rx_state_q != ST_IDLE) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
        case (rx_state_q)
            ST_IDLE: begin
                if (srx_prev_q && !srx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = CW'(1);
                end
            end
            ST_START: begin
                if (rx_sample) begin
                    rx_cnt_d = CW'(1);
                    if (srx_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                        rx_par_d   = 1'b0;
                        rx_perr_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_sample) begin
                    rx_cnt_d   = CW'(1);
                    rx_shift_d = {srx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_par_d   = rx_par_q ^ srx_sync_q;
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_sample) begin
                    rx_cnt_d   = CW'(1);
                    rx_perr_d  = ((rx_par_q ^ srx_sync_q) != ODD_PAR);
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_sample) begin
                    rx_state_d = ST_IDLE;
                    frame_set  = !srx_sync_q;
                    parity_set = rx_perr_q;
                    rx_push_d  = srx_sync_q && !rx_perr_q;
                    rx_byte_d  = rx_shift_q;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overrun_d    = overrun_set ? 1'b1 : (bus.err_clear ? 1'b0 : overrun_q);
        frame_err_d  = frame_set   ? 1'b1 : (bus.err_clear ? 1'b0 : frame_err_q);
        parity_err_d = parity_set  ? 1'b1 : (bus.err_clear ? 1'b0 : parity_err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            stx_q        <= 1'b1;
            srx_meta_q   <= 1'b1;
            srx_sync_q   <= 1'b1;
            srx_prev_q   <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_push_q    <= 1'b0;
            rx_byte_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            stx_q        <= stx_d;
            srx_meta_q   <= srx_meta_d;
            srx_sync_q   <= srx_sync_d;
            srx_prev_q   <= srx_prev_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            rx_perr_q    <= rx_perr_d;
            rx_push_q    <= rx_push_d;
            rx_byte_q    <= rx_byte_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Storage is not reset; an empty FIFO masks the head to zero instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rx_byte_q;
        end
    end
endmodule
